// File: rtl/ace_ccu_pkg.sv
// Shared types for the ACE CCU conflict tracker: tracked-entry layout and
// the line-address split into {tag, idx}.
package ace_ccu_pkg;

  localparam int unsigned CtAddrWidth = 32;
  localparam int unsigned CtIdxWidth  = 4;
  localparam int unsigned CtTagWidth  = CtAddrWidth - CtIdxWidth;

  typedef logic [CtTagWidth-1:0] ct_tag_t;
  typedef logic [CtIdxWidth-1:0] ct_idx_t;

  typedef struct packed {
    ct_tag_t tag;
    logic    valid;
  } ct_entry_t;

  typedef struct packed {
    ct_tag_t tag;
    ct_idx_t idx;
  } ct_split_t;

  function automatic ct_split_t ct_split(input logic [CtAddrWidth-1:0] addr);
    ct_split_t s;
    s.tag = addr[CtAddrWidth-1:CtIdxWidth];
    s.idx = addr[CtIdxWidth-1:0];
    return s;
  endfunction

endpackage

// File: rtl/ace_ccu_ct_free_sel.sv
// Per-set free-way selector: free-way count plus the rank-th lowest free way
// as a one-hot vector.
module ace_ccu_ct_free_sel #(
  parameter int unsigned NumWays  = 2,
  parameter int unsigned CntWidth = 3
) (
  input  logic [NumWays-1:0]  free_ways,
  input  logic [CntWidth-1:0] rank,
  output logic [NumWays-1:0]  sel,
  output logic [CntWidth-1:0] free_cnt
);

  // free-way population count (independent of rank)
  always_comb begin
    free_cnt = '0;
    for (int w = 0; w < NumWays; w++) begin
      free_cnt = free_cnt + CntWidth'(free_ways[w]);
    end
  end

  // pick the free way whose running free index equals rank
  always_comb begin
    logic [CntWidth-1:0] run;
    run = '0;
    sel = '0;
    for (int w = 0; w < NumWays; w++) begin
      sel[w] = free_ways[w] && (run == rank);
      if (free_ways[w]) begin
        run = run + CntWidth'(1);
      end else begin
        run = run;
      end
    end
  end

endmodule

// File: rtl/ace_ccu_conflict_tracker.sv
// Set-associative tracker of in-flight snoop line addresses for the ACE CCU.
// Optional statistics outputs are enabled with `define ACE_CCU_CT_STATS_EN.
module ace_ccu_conflict_tracker
  import ace_ccu_pkg::*;
#(
  parameter int unsigned CmAddrWidth  = CtAddrWidth,
  parameter int unsigned IdxWidth     = CtIdxWidth,
  parameter int unsigned NumWays      = 2,
  parameter int unsigned NoSnoopPorts = 2,
  parameter int unsigned NoRespPorts  = 4,
  parameter type         entry_t      = ct_entry_t,
  localparam int unsigned NumSets     = 2 ** IdxWidth,
  localparam int unsigned NumEntries  = NumSets * NumWays,
  localparam int unsigned OccWidth    = $clog2(NumEntries + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NoSnoopPorts-1:0]                   snoop_valid_i,
  input  logic [NoSnoopPorts-1:0]                   snoop_ready_i,
  input  logic [NoSnoopPorts-1:0][CmAddrWidth-1:0]  snoop_addr_i,
  output logic [NoSnoopPorts-1:0]                   snoop_stall_o,
  input  logic [NoRespPorts-1:0]                    clr_valid_i,
  input  logic [NoRespPorts-1:0][CmAddrWidth-1:0]   clr_addr_i,
  output logic [NoRespPorts-1:0]                    clr_miss_o,
  output logic [OccWidth-1:0]                       occupancy_o,
`ifdef ACE_CCU_CT_STATS_EN
  output logic [31:0]                               stall_cnt_o,
  output logic [OccWidth-1:0]                       hwm_o,
`endif
  output logic                                      full_o
);

  localparam int unsigned CntWidth = $clog2(NumWays + NoSnoopPorts + 1);

  entry_t                          entries_r [NumSets][NumWays];
  entry_t                          entries_s [NumSets][NumWays];
  ct_split_t                       snp_s     [NoSnoopPorts];
  ct_split_t                       clr_s     [NoRespPorts];
  logic [NumWays-1:0]              free_vec_s[NoSnoopPorts];
  logic [NumWays-1:0]              sel_s     [NoSnoopPorts];
  logic [CntWidth-1:0]             free_cnt_s[NoSnoopPorts];
  logic [CntWidth-1:0]             rank_s    [NoSnoopPorts];
  logic [NoSnoopPorts-1:0]         hit_s;
  logic [NoSnoopPorts-1:0]         stall_s;
  logic [NoSnoopPorts-1:0]         alloc_s;
  logic [NumSets-1:0][NumWays-1:0] clr_mask_s;
  logic [NoRespPorts-1:0]          clr_hit_s;
  logic [NoRespPorts-1:0]          clr_miss_r;
  logic [OccWidth-1:0]             alloc_cnt_s;
  logic [OccWidth-1:0]             clr_cnt_s;
  logic [OccWidth-1:0]             occ_s;
  logic [OccWidth-1:0]             occ_r;
  logic                            full_r;

  // split every snoop and clear address into {tag, idx}
  always_comb begin
    for (int p = 0; p < NoSnoopPorts; p++) begin
      snp_s[p] = ct_split(snoop_addr_i[p]);
    end
    for (int r = 0; r < NoRespPorts; r++) begin
      clr_s[r] = ct_split(clr_addr_i[r]);
    end
  end

  // registered-state lookup of each snoop's set: tag hit and free ways
  always_comb begin
    logic [NoSnoopPorts-1:0] hit_v;
    hit_v = '0;
    for (int p = 0; p < NoSnoopPorts; p++) begin
      for (int w = 0; w < NumWays; w++) begin
        free_vec_s[p][w] = !entries_r[snp_s[p].idx][w].valid;
        hit_v[p] = hit_v[p] | (entries_r[snp_s[p].idx][w].valid &&
                               (entries_r[snp_s[p].idx][w].tag == snp_s[p].tag));
      end
    end
    hit_s = hit_v;
  end

  for (genvar p = 0; p < NoSnoopPorts; p++) begin : g_free_sel
    ace_ccu_ct_free_sel #(
      .NumWays (NumWays),
      .CntWidth(CntWidth)
    ) u_free_sel (
      .free_ways(free_vec_s[p]),
      .rank     (rank_s[p]),
      .sel      (sel_s[p]),
      .free_cnt (free_cnt_s[p])
    );
  end

  // Stall resolution in channel priority order. Lower channels claim ways on
  // valid && !stall alone so that no stall ever depends on a ready.
  always_comb begin
    logic [NoSnoopPorts-1:0] stall_v;
    logic [CntWidth-1:0]     claims;
    logic                    dup;
    stall_v = '0;
    for (int p = 0; p < NoSnoopPorts; p++) begin
      claims = '0;
      dup    = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (snoop_valid_i[q] && !stall_v[q] && (snp_s[q].idx == snp_s[p].idx)) begin
          claims = claims + CntWidth'(1);
          dup    = dup | (snp_s[q].tag == snp_s[p].tag);
        end else begin
          claims = claims;
        end
      end
      if (snoop_valid_i[p]) begin
        stall_v[p] = hit_s[p] || (free_cnt_s[p] <= claims) || dup;
      end else begin
        stall_v[p] = 1'b0;
      end
    end
    stall_s = stall_v;
  end

  // accepted allocations and their rank among same-set allocations
  always_comb begin
    logic [NoSnoopPorts-1:0] alloc_v;
    alloc_v     = snoop_valid_i & snoop_ready_i & ~stall_s;
    alloc_cnt_s = '0;
    for (int p = 0; p < NoSnoopPorts; p++) begin
      rank_s[p]   = '0;
      alloc_cnt_s = alloc_cnt_s + OccWidth'(alloc_v[p]);
      for (int q = 0; q < p; q++) begin
        if (alloc_v[q] && (snp_s[q].idx == snp_s[p].idx)) begin
          rank_s[p] = rank_s[p] + CntWidth'(1);
        end else begin
          rank_s[p] = rank_s[p];
        end
      end
    end
    alloc_s = alloc_v;
  end

  // clear matching: several ports on one entry collapse into one mask bit
  always_comb begin
    logic [NumSets-1:0][NumWays-1:0] mask_v;
    logic [NoRespPorts-1:0]          hit_v;
    mask_v = '0;
    hit_v  = '0;
    for (int r = 0; r < NoRespPorts; r++) begin
      for (int w = 0; w < NumWays; w++) begin
        if (clr_valid_i[r] && entries_r[clr_s[r].idx][w].valid &&
            (entries_r[clr_s[r].idx][w].tag == clr_s[r].tag)) begin
          mask_v[clr_s[r].idx][w] = 1'b1;
          hit_v[r]                = 1'b1;
        end else begin
          hit_v[r] = hit_v[r];
        end
      end
    end
    clr_cnt_s = '0;
    for (int s = 0; s < NumSets; s++) begin
      for (int w = 0; w < NumWays; w++) begin
        clr_cnt_s = clr_cnt_s + OccWidth'(mask_v[s][w]);
      end
    end
    clr_mask_s = mask_v;
    clr_hit_s  = hit_v;
  end

  // next entry state; allocations only target free ways, clears only valid ones
  always_comb begin
    for (int s = 0; s < NumSets; s++) begin
      for (int w = 0; w < NumWays; w++) begin
        entries_s[s][w] = entries_r[s][w];
        if (clr_mask_s[s][w]) begin
          entries_s[s][w].valid = 1'b0;
        end else begin
          entries_s[s][w].valid = entries_r[s][w].valid;
        end
      end
    end
    for (int p = 0; p < NoSnoopPorts; p++) begin
      for (int w = 0; w < NumWays; w++) begin
        if (alloc_s[p] && sel_s[p][w]) begin
          entries_s[snp_s[p].idx][w].tag   = snp_s[p].tag;
          entries_s[snp_s[p].idx][w].valid = 1'b1;
        end else begin
          entries_s[snp_s[p].idx][w] = entries_s[snp_s[p].idx][w];
        end
      end
    end
    occ_s = occ_r + alloc_cnt_s - clr_cnt_s;
  end

  // table and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSets; s++) begin
        for (int w = 0; w < NumWays; w++) begin
          entries_r[s][w] <= '0;
        end
      end
      occ_r      <= '0;
      full_r     <= 1'b0;
      clr_miss_r <= '0;
    end else begin
      entries_r  <= entries_s;
      occ_r      <= occ_s;
      full_r     <= (occ_s == OccWidth'(NumEntries));
      clr_miss_r <= clr_valid_i & ~clr_hit_s;
    end
  end

`ifdef ACE_CCU_CT_STATS_EN
  logic [31:0]         stall_cnt_r;
  logic [OccWidth-1:0] hwm_r;

  // stall-cycle counter and occupancy high-water mark
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 32'd0;
      hwm_r       <= '0;
    end else begin
      if (|(snoop_valid_i & stall_s)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (occ_s > hwm_r) begin
        hwm_r <= occ_s;
      end else begin
        hwm_r <= hwm_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign hwm_o       = hwm_r;
`endif

  assign snoop_stall_o = stall_s;
  assign clr_miss_o    = clr_miss_r;
  assign occupancy_o   = occ_r;
  assign full_o        = full_r;

endmodule

// File: tb/tb_ace_ccu_conflict_tracker.sv
// Directed plus randomized bench for ace_ccu_conflict_tracker, checked
// against an address-list model of the outstanding snoops.
module tb_ace_ccu_conflict_tracker;

  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int NW   = 2;
  localparam int NS   = 2;
  localparam int NR   = 4;
  localparam int NENT = 32;
  localparam int OW   = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NS-1:0]          sv, sr, stall;
  logic [NS-1:0][AW-1:0]  sa;
  logic [NR-1:0]          cv, miss;
  logic [NR-1:0][AW-1:0]  ca;
  logic [OW-1:0]          occ;
  logic                   full;
`ifdef ACE_CCU_CT_STATS_EN
  logic [31:0]            stall_cnt;
  logic [OW-1:0]          hwm;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [AW-1:0] mdl[$];
  logic [NR-1:0] exp_miss = '0;

  always #5 clk = ~clk;

  ace_ccu_conflict_tracker dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .snoop_valid_i(sv),
    .snoop_ready_i(sr),
    .snoop_addr_i (sa),
    .snoop_stall_o(stall),
    .clr_valid_i  (cv),
    .clr_addr_i   (ca),
    .clr_miss_o   (miss),
    .occupancy_o  (occ),
`ifdef ACE_CCU_CT_STATS_EN
    .stall_cnt_o  (stall_cnt),
    .hwm_o        (hwm),
`endif
    .full_o       (full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_has(input logic [AW-1:0] a);
    foreach (mdl[i]) if (mdl[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int mdl_set(input logic [IW-1:0] s);
    int n = 0;
    foreach (mdl[i]) if (mdl[i][IW-1:0] == s) n++;
    return n;
  endfunction

  task automatic idle();
    sv = '0; sr = '0; sa = '0; cv = '0; ca = '0;
  endtask

  // One clock: predict stalls and misses from the outstanding list, check
  // the combinational stall mid-cycle, then the registered outputs.
  task automatic run_cycle();
    logic [NS-1:0] es;
    logic [NR-1:0] nm;
    int claims;
    bit dup;
    for (int p = 0; p < NS; p++) begin
      es[p] = 1'b0;
      if (sv[p]) begin
        claims = 0;
        dup = 1'b0;
        for (int q = 0; q < p; q++) begin
          if (sv[q] && !es[q] && sa[q][IW-1:0] == sa[p][IW-1:0]) begin
            claims++;
            if (sa[q] == sa[p]) dup = 1'b1;
          end
        end
        es[p] = mdl_has(sa[p]) || (NW - mdl_set(sa[p][IW-1:0]) - claims <= 0) || dup;
      end
    end
    for (int r = 0; r < NR; r++) nm[r] = cv[r] && !mdl_has(ca[r]);
    @(negedge clk);
    check("stall", 32'(stall), 32'(es));
    for (int r = 0; r < NR; r++) begin
      if (cv[r]) begin
        for (int i = mdl.size() - 1; i >= 0; i--) if (mdl[i] == ca[r]) mdl.delete(i);
      end
    end
    for (int p = 0; p < NS; p++) if (sv[p] && sr[p] && !es[p]) mdl.push_back(sa[p]);
    exp_miss = nm;
    @(posedge clk);
    #1;
    check("occupancy", 32'(occ), 32'(mdl.size()));
    check("full", 32'(full), 32'(mdl.size() == NENT));
    check("clr_miss", 32'(miss), 32'(exp_miss));
  endtask

  task automatic rand_cycle();
    for (int p = 0; p < NS; p++) begin
      sv[p] = ($urandom_range(0, 3) != 0);
      sr[p] = ($urandom_range(0, 3) != 0);
      sa[p] = AW'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
    end
    for (int r = 0; r < NR; r++) begin
      cv[r] = ($urandom_range(0, 2) == 0);
      if (!cv[r]) ca[r] = $urandom;
      else if (mdl.size() > 0 && $urandom_range(0, 3) != 0)
        ca[r] = mdl[$urandom_range(0, mdl.size() - 1)];
      else
        ca[r] = AW'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
    end
    run_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    check("rst_occupancy", 32'(occ), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_clr_miss", 32'(miss), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single allocation, then a repeat of the same line stalls
    sv = 2'b01; sr = 2'b01; sa[0] = 32'h1230;
    run_cycle();
    check("first_alloc_occ", 32'(occ), 32'd1);
    run_cycle();
    check("repeat_stall", 32'(stall), 32'd1);
    idle(); cv[0] = 1'b1; ca[0] = 32'h1230;
    run_cycle();

    // two ports fill set 0, a third line in the set stalls
    idle(); sv = 2'b11; sr = 2'b11; sa[0] = 32'h0010; sa[1] = 32'h0020;
    run_cycle();
    check("two_port_occ", 32'(occ), 32'd2);
    idle(); sv = 2'b01; sr = 2'b01; sa[0] = 32'h0030;
    run_cycle();
    idle(); cv = 4'b0011; ca[0] = 32'h0010; ca[1] = 32'h0020;
    run_cycle();

    // same line on both ports: port1 stalls
    idle(); sv = 2'b11; sr = 2'b11; sa[0] = 32'h0450; sa[1] = 32'h0450;
    run_cycle();

    // clear and snoop of the same line in one cycle: snoop still stalls
    idle(); sv = 2'b01; sr = 2'b01; sa[0] = 32'h0450; cv[0] = 1'b1; ca[0] = 32'h0450;
    run_cycle();
    idle(); sv = 2'b01; sr = 2'b01; sa[0] = 32'h0450;
    run_cycle();

    // double clear of one entry plus an unmatched clear
    idle(); cv = 4'b0111; ca[0] = 32'h0450; ca[1] = 32'h0450; ca[2] = 32'h0777;
    run_cycle();
    check("miss_pulse", 32'(miss), 32'b0100);
    idle(); ca[3] = 32'h0777;
    run_cycle();
    check("miss_one_cycle", 32'(miss), 32'd0);

    repeat (400) rand_cycle();

    idle();
    for (int i = 0; i < 20 && mdl.size() > 0; i++) begin
      idle();
      for (int r = 0; r < NR; r++) if (r < mdl.size()) begin cv[r] = 1'b1; ca[r] = mdl[r]; end
      run_cycle();
    end
    check("drained", 32'(occ), 32'd0);

    // fill every entry
    for (int s = 0; s < 16; s++) begin
      idle(); sv = 2'b11; sr = 2'b11;
      sa[0] = 32'h10 | 32'(s); sa[1] = 32'h20 | 32'(s);
      run_cycle();
    end
    check("full_set", 32'(full), 32'd1);
    check("full_occ", 32'(occ), 32'd32);

    // asynchronous reset in the middle of a cycle with traffic present
    idle(); sv = 2'b01; sr = 2'b01; sa[0] = 32'h0010;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_occ", 32'(occ), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_miss", 32'(miss), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    mdl.delete();
    exp_miss = '0;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (30) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ace_ccu_conflict_tracker.md
Name: ace_ccu_conflict_tracker

Overview:
Set-associative table of in-flight snoop line addresses for the ACE CCU. It is the parametrised successor of the single-port conflict manager.
- Stalls any new snoop whose address matches an outstanding entry, or whose set has no free way.
- Accepts NoSnoopPorts snoop requests per cycle.
- Releases entries only on qualified completion requests from the response ports.
- Reports occupancy and full status.

Parameters:
CmAddrWidth, 32, tracked address width (line address, index in the LSBs).
IdxWidth, 4, set-index width; NumSets = 2**IdxWidth.
NumWays, 2, ways per set (>=1, any value, not required to be a power of two).
NoSnoopPorts, 2, parallel snoop request channels.
NoRespPorts, 4, completion (clear) channels.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset; asynchronous, active-low.
snoop_valid_i  in  NoSnoopPorts  snoop request valid per channel.
snoop_ready_i  in  NoSnoopPorts  downstream accepts the snoop this cycle.
snoop_addr_i  in  NoSnoopPorts x CmAddrWidth  snoop line address.
snoop_stall_o  out  NoSnoopPorts  combinational: the channel must not proceed.
clr_valid_i  in  NoRespPorts  completion valid.
clr_addr_i  in  NoRespPorts x CmAddrWidth  completed line address.
clr_miss_o  out  NoRespPorts  registered one-cycle pulse: valid clear matched no entry.
occupancy_o  out  $clog2(NumSets*NumWays+1)  registered count of valid entries.
full_o  out  1  registered; occupancy == NumSets*NumWays.

Behaviour:
- Address split: tag = addr[CmAddrWidth-1:IdxWidth], idx = addr[IdxWidth-1:0].
- Entry state: {valid, tag} per way/set, all registered. Reset clears every valid bit. occupancy_o = 0, full_o = 0, clr_miss_o = 0.
- Reset asserted mid-operation discards all entries immediately. No pending state survives.
- Hit and free-way checks use registered (q) state only.
- Stall for channel p, evaluated only when snoop_valid_i[p] (otherwise stall = 0). Stall is asserted when any of the following holds:
  - (a) a valid entry in set idx_p has tag_p;
  - (b) the free ways remaining in set idx_p, after allocations by lower-index channels this cycle, are zero;
  - (c) a lower-index channel q<p has valid && !stall && the same idx and tag.
- Stall is never a function of snoop_ready_i, so there is no combinational loop with the ready.
- Allocation: valid && ready && !stall on channel p sets the k-th lowest free way of idx_p, where k = number of lower-index channels allocating into the same set this cycle. Entry becomes valid the next cycle. Latency 1.
- Clear: clr_valid_i[r] && a valid entry in set idx_r matches tag_r clears that way; the entry is invalid the next cycle.
  - Multiple clear ports hitting the same entry clear it once, with no miss flagged.
  - clr_valid_i with no match raises clr_miss_o[r] next cycle.
  - clr_addr_i is ignored when its valid is low.
- Clear and allocation in the same cycle:
  - A way freed this cycle is not reusable until the next cycle.
  - A snoop matching an entry being cleared still stalls this cycle.
  - Allocation and clear therefore never target the same way in one cycle.
- occupancy_d = occupancy_q + allocations − clears (per-cycle counts, saturating is not needed by construction). full_o is derived from occupancy_d and registered.

Optional Feature:
ACE_CCU_CT_STATS_EN:
- When defined, adds the following outputs:
  - stall_cnt_o [31:0]: counts cycles with any snoop_valid_i && snoop_stall_o, wraps at 2^32.
  - hwm_o: occupancy high-water mark, same width as occupancy_o, registered.
  - Both reset to 0.
- When undefined, these ports and their registers are absent, and behaviour is otherwise identical.

Decomposition:
- ace_ccu_pkg gains the ct_entry_t struct {tag, valid} and a function ct_split(addr) returning {tag, idx}. Both are parametrised through localparams of this module via a type parameter.
- Sub-module ace_ccu_ct_free_sel: per-set combinational selector that returns the k-th lowest free way plus a free-way count. It is instantiated once per snoop channel.

Test Plan:
- Reset, then port0 snoop 0x1230 with ready -> stall 0; occupancy 1 next cycle. Repeat 0x1230 -> stall 1.
- Two ports in the same cycle, 0x0010 and 0x0020 (same idx 0, NumWays=2) -> both allocate into ways 0 and 1. A third snoop 0x0030 -> stall (set full).
- Both ports send 0x0450 in the same cycle -> port0 stall 0, port1 stall 1; occupancy +1.
- Entry 0x0450 valid; clr 0x0450 and snoop 0x0450 in the same cycle -> snoop stalls. Next cycle the same snoop -> stall 0.
- clr 0x0777 with no entry -> clr_miss_o[r] = 1 for exactly one cycle; occupancy unchanged.
- Fill all 32 entries -> full_o = 1. Assert rst_ni low mid-traffic -> all entries, occupancy_o, and full_o are 0 asynchronously.
